// File: rtl/pc_fetch_sequencer.sv
// Fetch controller: owns the PC, issues one imem read at a time over req/ack,
// and holds each fetched instruction until the decoder accepts it and redirects.
module pc_fetch_sequencer #(
    parameter int unsigned   AW       = 16,
    parameter int unsigned   DW       = 16,
    parameter int unsigned   DISPW    = 8,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             En,
    output logic             imem_req,
    output logic [AW-1:0]    imem_addr,
    input  logic             imem_ack,
    input  logic [DW-1:0]    imem_rdata,
    output logic             instr_valid,
    output logic [DW-1:0]    instr,
    output logic [AW-1:0]    instr_addr,
    input  logic             dec_ready,
    input  logic             jump,
    input  logic [AW-1:0]    Rdest,
    input  logic             branch,
    input  logic             cond,
    input  logic [DISPW-1:0] disp,
    output logic [AW-1:0]    pc,
    output logic [15:0]      fetch_count
);

    localparam int unsigned XW = AW - DISPW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            req_q, req_d;
    logic            valid_q, valid_d;
    logic [DW-1:0]   instr_q, instr_d;
    logic [AW-1:0]   instr_addr_q, instr_addr_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [15:0]     count_q, count_d;
    logic [AW-1:0]   disp_ext;
    logic [AW-1:0]   branch_tgt;

    // Branch target is relative to the accepted instruction, not the already-advanced PC.
    assign disp_ext   = {{XW{disp[DISPW-1]}}, disp};
    assign branch_tgt = instr_addr_q + disp_ext;

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        instr_addr_d = instr_addr_q;
        pc_d         = pc_q;
        count_d      = count_q;
        case (state_q)
            S_IDLE: begin
                if (En) begin
                    state_d = S_FETCH;
                    req_d   = 1'b1;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d      = imem_rdata;
                    instr_addr_d = pc_q;
                    pc_d         = pc_q + AW'(1);
                    req_d        = 1'b0;
                    valid_d      = 1'b1;
                    state_d      = S_VALID;
                end
            end
            S_VALID: begin
                if (dec_ready) begin
                    count_d = count_q + 16'd1;
                    if (jump) begin
                        pc_d = Rdest;
                    end else if (branch && cond) begin
                        pc_d = branch_tgt;
                    end
                    valid_d = 1'b0;
                    req_d   = En;
                    state_d = En ? S_FETCH : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            req_q        <= 1'b0;
            valid_q      <= 1'b0;
            instr_q      <= '0;
            instr_addr_q <= '0;
            pc_q         <= RESET_PC;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            instr_addr_q <= instr_addr_d;
            pc_q         <= pc_d;
            count_q      <= count_d;
        end
    end

    // The request address is the PC register itself, so it cannot go stale.
    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_addr  = instr_addr_q;
    assign pc          = pc_q;
    assign fetch_count = count_q;

endmodule
